// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and data access onto one single-port memory
// Ports: clk/rst_n (async active-low); if_req/if_addr fetch request; d_re/d_we/d_addr/d_wdata data request;
//        mem_* shared memory side (registered address/data/strobes, mem_rdy completion);
//        if_rdata/if_valid, d_rdata/d_valid completion; stall_if/stall_d combinational stalls; err timeout pulse.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] if_rdata,
  output logic [15:0] d_rdata,
  output logic        if_valid,
  output logic        d_valid,
  output logic        stall_if,
  output logic        stall_d,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       w_dreq, w_blk, w_tout;
  assign w_dreq   = d_re | d_we;
  // a requester still sees its request high during its valid cycle; don't regrant it
  assign w_blk    = if_valid | d_valid;
  assign w_tout   = r_cnt == 4'(TIMEOUT - 1);
  assign stall_if = if_req & ~if_valid;
  assign stall_d  = w_dreq & ~d_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_blk && w_dreq) begin
            r_state   <= DATA;
            r_cnt     <= '0;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_we    <= d_we;
            mem_re    <= d_re & ~d_we;
          end else if (!w_blk && if_req) begin
            r_state   <= FETCH;
            r_cnt     <= '0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b1;
          end
        end
        default: begin
          if (mem_rdy || w_tout) begin
            r_state <= IDLE;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            err     <= ~mem_rdy;
            if (r_state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdy ? mem_rdata : 16'h0000;
            end else begin
              d_valid <= 1'b1;
              // writes leave d_rdata alone; a timeout clears it
              if (!mem_rdy) d_rdata <= 16'h0000;
              else if (mem_re) d_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_re, d_we, mem_rdy;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, if_rdata, d_rdata;
  logic        mem_re, mem_we, if_valid, d_valid, stall_if, stall_d, err;
  int          n_chk = 0;
  int          n_err = 0;
  typedef struct {
    logic        is_d;
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];
  mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .if_rdata(if_rdata), .d_rdata(d_rdata),
    .if_valid(if_valid), .d_valid(d_valid), .stall_if(stall_if), .stall_d(stall_d), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic is_d, input logic [15:0] rdata, input logic e);
    exp_t x;
    x.is_d  = is_d;
    x.rdata = rdata;
    x.err   = e;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    if (rst_n && (if_valid || d_valid)) begin
      if (q.size() == 0) chk("sb_unexpected_valid", {if_valid, d_valid}, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_both_valid", if_valid & d_valid, 0);
        chk("sb_path", d_valid, e.is_d);
        chk("sb_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        chk("sb_err", err, e.err);
      end
    end
  end
  initial begin
    int n;
    rst_n = 1'b0; if_req = 0; d_re = 0; d_we = 0; mem_rdy = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    tick(2);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_pulses", {if_valid, d_valid, err}, 0);
    rst_n = 1'b1;
    // single fetch, mem_rdy two cycles after grant
    if_req = 1; if_addr = 16'h0010;
    push(0, 16'hB123, 0);
    #1 chk("stall_if_pending", stall_if, 1);
    tick();
    chk("f_mem_re", mem_re, 1);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_addr", mem_addr, 16'h0010);
    chk("f_mem_wdata", mem_wdata, 16'h0000);
    tick();
    chk("f_hold_re", mem_re, 1);
    chk("f_hold_addr", mem_addr, 16'h0010);
    mem_rdy = 1; mem_rdata = 16'hB123;
    tick();
    chk("f_if_valid", if_valid, 1);
    chk("f_stall_if_low", stall_if, 0);
    chk("f_strobe_drop", mem_re, 0);
    if_req = 0; mem_rdy = 0;
    tick();
    chk("f_valid_one_cycle", if_valid, 0);
    chk("f_no_regrant", mem_re, 0);
    // simultaneous fetch and data read: data wins
    if_req = 1; if_addr = 16'h0020; d_re = 1; d_addr = 16'h8000;
    push(1, 16'h5555, 0);
    push(0, 16'h1234, 0);
    tick();
    chk("p_data_addr", mem_addr, 16'h8000);
    chk("p_data_re", mem_re, 1);
    mem_rdy = 1; mem_rdata = 16'h5555;
    tick();
    chk("p_d_valid", d_valid, 1);
    chk("p_if_not_valid", if_valid, 0);
    d_re = 0; mem_rdy = 0;
    #1 chk("p_stalls", {stall_if, stall_d}, 2'b10);
    tick();
    chk("p_blocked_in_valid", mem_re, 0);
    tick();
    chk("p_fetch_re", mem_re, 1);
    chk("p_fetch_addr", mem_addr, 16'h0020);
    mem_rdy = 1; mem_rdata = 16'h1234;
    tick();
    chk("p_if_valid", if_valid, 1);
    if_req = 0; mem_rdy = 0;
    tick();
    // data write, mem_rdy after one wait cycle
    d_we = 1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
    push(1, 16'h5555, 0);
    tick();
    chk("w_mem_we", mem_we, 1);
    chk("w_mem_re", mem_re, 0);
    chk("w_mem_wdata", mem_wdata, 16'hBEEF);
    chk("w_mem_addr", mem_addr, 16'h0042);
    tick();
    mem_rdy = 1; mem_rdata = 16'hDEAD;
    tick();
    chk("w_d_valid", d_valid, 1);
    d_we = 0; mem_rdy = 0;
    tick();
    // read and write together: write wins
    d_re = 1; d_we = 1; d_addr = 16'h0044; d_wdata = 16'h1111;
    push(1, 16'h5555, 0);
    tick();
    chk("rw_strobes", {mem_we, mem_re}, 2'b10);
    mem_rdy = 1; mem_rdata = 16'hABCD;
    tick();
    d_re = 0; d_we = 0; mem_rdy = 0;
    tick();
    // data read timeout
    d_re = 1; d_addr = 16'h0100;
    push(1, 16'h0000, 1);
    tick();
    chk("t_grant", mem_re, 1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (d_valid) begin
        n = i;
        break;
      end
    end
    chk("t_cycles", n, 15);
    chk("t_err", err, 1);
    chk("t_strobe_drop", mem_re, 0);
    d_re = 0;
    tick();
    chk("t_pulses_end", {err, d_valid}, 0);
    // mem_rdy while idle is ignored
    mem_rdy = 1; mem_rdata = 16'hFFFF;
    tick();
    chk("i_no_valid", {if_valid, d_valid, mem_re}, 0);
    chk("i_rdata_kept", {if_rdata, d_rdata}, {16'h1234, 16'h0000});
    mem_rdy = 0;
    // reset mid-fetch
    if_req = 1; if_addr = 16'h0030;
    tick();
    chk("r_grant", mem_re, 1);
    tick();
    #2 rst_n = 0;
    #1 chk("r_async_re", mem_re, 0);
    chk("r_async_addr", mem_addr, 0);
    tick();
    chk("r_no_valid", if_valid, 0);
    if_addr = 16'h0040;
    rst_n = 1;
    push(0, 16'h7777, 0);
    tick();
    chk("r_new_grant", {mem_re, mem_addr}, {1'b1, 16'h0040});
    mem_rdy = 1; mem_rdata = 16'h7777;
    tick();
    chk("r_if_valid", if_valid, 1);
    if_req = 0; mem_rdy = 0;
    tick(2);
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max wait cycles for mem_rdy per access, range 2..15.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  instruction-fetch request; held high until if_valid.
REQ-005 if_addr  input  16  fetch address (PC).
REQ-006 d_re  input  1  data read request (MemRead from control logic; LW, RET); held until d_valid.
REQ-007 d_we  input  1  data write request (MemWrite; SW, CALL); held until d_valid.
REQ-008 d_addr  input  16  data address.
REQ-009 d_wdata  input  16  store data.
REQ-010 mem_rdata  input  16  shared single-port memory read data, valid with mem_rdy.
REQ-011 mem_rdy  input  1  memory completion strobe.
REQ-012 mem_addr  output  16  registered memory address.
REQ-013 mem_wdata  output  16  registered memory write data.
REQ-014 mem_re / mem_we  output  1 each  registered memory strobes.
REQ-015 if_rdata / d_rdata  output  16 each  registered read data to requester.
REQ-016 if_valid / d_valid  output  1 each  one-cycle completion pulses.
REQ-017 stall_if / stall_d  output  1 each  combinational pipeline stall: requester pending and its valid low.
REQ-018 err  output  1  one-cycle pulse on timeout.

Function
REQ-019 FSM states IDLE, FETCH, DATA; one access outstanding at most.
REQ-020 IDLE: if (d_re|d_we) go DATA; else if if_req go FETCH; else stay; data has fixed priority over fetch.
REQ-021 Requests ignored in any cycle where if_valid or d_valid is high (prevents regrant of a completing request).
REQ-022 On grant edge: mem_addr, mem_wdata (d_wdata for DATA, 16'h0000 for FETCH), mem_re, mem_we latched and held constant for whole access.
REQ-023 FETCH drives mem_re=1, mem_we=0; DATA drives mem_we=d_we, mem_re=d_re&~d_we (write wins if both set).
REQ-024 Wait counter (4 bits) clears on grant, increments each FETCH/DATA cycle with mem_rdy=0.
REQ-025 mem_rdy=1 in FETCH: if_rdata<=mem_rdata, if_valid=1 next cycle, strobes drop, state IDLE.
REQ-026 mem_rdy=1 in DATA: d_rdata<=mem_rdata on read (unchanged on write), d_valid=1 next cycle, state IDLE.
REQ-027 Timeout: counter==TIMEOUT-1 with mem_rdy=0 -> IDLE, err=1 and corresponding valid=1 next cycle, rdata=16'h0000.
REQ-028 Minimum access latency: grant cycle + 1 memory cycle + valid cycle = 3 cycles from request to valid; back-to-back accesses separated by the valid cycle.
REQ-029 mem_rdy while IDLE ignored; no output change.
REQ-030 stall_if=if_req&~if_valid; stall_d=(d_re|d_we)&~d_valid; no registered delay.

Reset
REQ-031 rst_n low immediately forces IDLE, counter 0, and all registered outputs (mem_addr, mem_wdata, mem_re, mem_we, if_rdata, d_rdata, if_valid, d_valid, err) to 0, including mid-access.
REQ-032 After rst_n release, first grant on first rising edge with a pending request; aborted access is not resumed.

Verification
REQ-033 if_req=1, if_addr=16'h0010, mem_rdy high 2 cycles after grant with mem_rdata=16'hB123 -> mem_re=1, mem_addr=16'h0010 for the access, if_rdata=16'hB123, if_valid one cycle, stall_if low in that cycle.
REQ-034 if_req and d_re asserted same cycle, d_addr=16'h8000 -> DATA granted first (mem_addr=16'h8000), fetch granted on the cycle after d_valid.
REQ-035 d_we=1, d_addr=16'h0042, d_wdata=16'hBEEF, mem_rdy after 1 cycle -> mem_we=1, mem_wdata=16'hBEEF, d_valid pulse, d_rdata unchanged.
REQ-036 d_re=1, mem_rdy held low -> after TIMEOUT (15) cycles in DATA, err and d_valid pulse together, d_rdata=16'h0000, state IDLE.
REQ-037 rst_n pulsed low during a FETCH wait -> mem_re drops without clock edge, no if_valid; new fetch after release completes normally.
REQ-038 d_re=d_we=1 -> mem_we=1, mem_re=0.
